// File: rtl/video_timing_ctrl_pkg.sv
// Shared types and 720p defaults for the HDMI frame scheduler.
// Phase and controller-state enums used by the counters and the top.
package video_timing_pkg;

    typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_e;
    typedef enum logic {IDLE, RUN} ctrl_state_e;

    localparam int PIX_W = 24;
    localparam int CNT_W = 12;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    localparam logic [PIX_W-1:0] UNDERFLOW_RGB_720P = 24'hFF00FF;

endpackage

// File: rtl/video_timing_ctrl_if.sv
// Pixel FIFO read port plus raster/pixel output bundle.
// master = the timing controller, slave = FIFO/encoder side.
interface video_timing_ctrl_if;
    import video_timing_pkg::*;

    logic             pix_empty;
    logic             pix_rd;
    logic [PIX_W-1:0] pix_data;
    logic             hsync_out;
    logic             vsync_out;
    logic             de_out;
    logic [CNT_W-1:0] x_out;
    logic [CNT_W-1:0] y_out;
    logic [PIX_W-1:0] rgb_out;
    logic             frame_start;

    modport master (
        input  pix_empty, pix_data,
        output pix_rd, hsync_out, vsync_out, de_out,
        output x_out, y_out, rgb_out, frame_start
    );

    modport slave (
        output pix_empty, pix_data,
        input  pix_rd, hsync_out, vsync_out, de_out,
        input  x_out, y_out, rgb_out, frame_start
    );

endinterface

// File: rtl/video_timing_ctrl_axis_counter.sv
// One raster axis: wrapping position counter with phase decode.
// Used once for horizontal clocks and once for vertical lines.
module timing_axis_counter
    import video_timing_pkg::*;
#(
    parameter int N_ACTIVE = 4,
    parameter int N_FP     = 2,
    parameter int N_SYNC   = 2,
    parameter int N_BP     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output phase_e           phase,
    output logic             last
);

    localparam int TOTAL = N_ACTIVE + N_FP + N_SYNC + N_BP;
    localparam logic [CNT_W-1:0] E_ACT  = CNT_W'(N_ACTIVE);
    localparam logic [CNT_W-1:0] E_FP   = CNT_W'(N_ACTIVE + N_FP);
    localparam logic [CNT_W-1:0] E_SYNC = CNT_W'(N_ACTIVE + N_FP + N_SYNC);
    localparam logic [CNT_W-1:0] E_LAST = CNT_W'(TOTAL - 1);

    assign last = (cnt == E_LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        phase = BP;
        unique case (1'b1)
            (cnt < E_ACT):                   phase = ACTIVE;
            (cnt >= E_ACT  && cnt < E_FP):   phase = FP;
            (cnt >= E_FP   && cnt < E_SYNC): phase = SYNC;
            (cnt >= E_SYNC):                 phase = BP;
            default:                         phase = BP;
        endcase
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// HDMI frame scheduler: raster timing, FIFO fetch look-ahead and
// underflow fill. Counters lead the registered outputs by one cycle.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter logic [PIX_W-1:0] UNDERFLOW_RGB = UNDERFLOW_RGB_720P
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic underflow_clr,
    output logic underflow,
    video_timing_ctrl_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] HA = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VA = CNT_W'(V_ACTIVE);

    if (H_ACTIVE < 2 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_params
        $error("video_timing_ctrl: timing parameters out of range");
    end

    ctrl_state_e      state;
    ctrl_state_e      next_state;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    phase_e           h_phase;
    phase_e           v_phase;
    logic             h_last;
    logic             v_last;
    logic             run;
    logic             frame_last;
    logic             restart;
    logic [CNT_W-1:0] nh;
    logic [CNT_W-1:0] nv;
    logic             next_act;
    logic             act0;
    logic             miss_q;

    timing_axis_counter #(
        .N_ACTIVE(H_ACTIVE), .N_FP(H_FP),
        .N_SYNC(H_SYNC),     .N_BP(H_BP)
    ) u_h (
        .clk(clk), .rst(rst), .clr(!run), .step(run),
        .cnt(h_cnt), .phase(h_phase), .last(h_last)
    );

    timing_axis_counter #(
        .N_ACTIVE(V_ACTIVE), .N_FP(V_FP),
        .N_SYNC(V_SYNC),     .N_BP(V_BP)
    ) u_v (
        .clk(clk), .rst(rst), .clr(!run), .step(run && h_last),
        .cnt(v_cnt), .phase(v_phase), .last(v_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    assign run        = (state == RUN);
    assign frame_last = run && h_last && v_last;
    assign restart    = !run || frame_last;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en) next_state = RUN;
            RUN:     if (frame_last && !en) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Position the counters will hold next cycle; fetching for it now
    // lands the data in rgb_out together with its de cycle.
    always_comb begin
        nh = '0;
        nv = '0;
        if (!restart) begin
            nh = h_last ? '0 : h_cnt + 1'b1;
            nv = h_last ? v_cnt + 1'b1 : v_cnt;
        end
    end

    assign next_act   = (next_state == RUN) && (nh < HA) && (nv < VA);
    assign act0       = run && (h_phase == ACTIVE) && (v_phase == ACTIVE);
    assign vif.pix_rd = !rst && next_act && !vif.pix_empty;

    always_ff @(posedge clk) begin
        if (rst) miss_q <= 1'b0;
        else     miss_q <= next_act && vif.pix_empty;
    end

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            vif.hsync_out   <= !HS_POL;
            vif.vsync_out   <= !VS_POL;
            vif.de_out      <= 1'b0;
            vif.x_out       <= '0;
            vif.y_out       <= '0;
            vif.rgb_out     <= '0;
            vif.frame_start <= 1'b0;
        end else begin
            vif.hsync_out   <= (h_phase == SYNC) ? HS_POL : !HS_POL;
            vif.vsync_out   <= (v_phase == SYNC) ? VS_POL : !VS_POL;
            vif.de_out      <= act0;
            vif.x_out       <= h_cnt;
            vif.y_out       <= v_cnt;
            vif.frame_start <= (h_cnt == '0) && (v_cnt == '0);
            if (!act0)       vif.rgb_out <= '0;
            else if (miss_q) vif.rgb_out <= UNDERFLOW_RGB;
            else             vif.rgb_out <= vif.pix_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) underflow <= 1'b0;
        else     underflow <= (act0 && miss_q) || (underflow && !underflow_clr);
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl on a 10x6 raster with a modelled FIFO.
// Reference works in linear frame positions, not RTL state.
module tb_video_timing_ctrl;
    import video_timing_pkg::*;

    localparam int HA = 4, HF = 2, HS = 2, HB = 2;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int N  = 2048;
    localparam logic [23:0] UF = 24'hFF00FF;

    logic clk = 1'b0;
    logic rst, en, underflow_clr, underflow;

    video_timing_ctrl_if vif();

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .UNDERFLOW_RGB(UF)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .underflow_clr(underflow_clr), .underflow(underflow),
        .vif(vif)
    );

    always #5 clk = ~clk;

    int          exp_pos [N];
    bit          miss_at [N];
    logic [23:0] exp_rgb [N];
    int          c = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          model_reads = 0;
    int          dut_reads = 0;
    logic [23:0] base;
    bit          rd_now;
    bit          exp_uf;
    bit          prev_rst = 1'b1;
    bit          prev_clr = 1'b0;
    bit          prev_uf = 1'b0;
    bit          checking = 1'b0;
    int          rd_count;

    function automatic bit act(int p);
        return p >= 0 && (p % HT) < HA && (p / HT) < VA;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)",
                   tag, obs, expv, c);
        end
    endtask

    // One clock: drive inputs, advance model, compare, serve FIFO.
    task automatic cyc(bit en_v, bit emp_v, bit rst_v, bit clr_v);
        int  p, p1, p2, px, py;
        bit  need;
        rst = rst_v;
        en = en_v;
        vif.pix_empty = emp_v;
        underflow_clr = clr_v;
        @(negedge clk);
        p = exp_pos[c];
        exp_uf = prev_rst ? 1'b0 :
                 ((act(p) && miss_at[c]) || (prev_uf && !prev_clr));
        need = 1'b0;
        if (rst_v) begin
            exp_pos[c+1] = -1;
            exp_pos[c+2] = -1;
        end else begin
            p1 = exp_pos[c+1];
            if (p1 < 0 || p1 == FT - 1) p2 = en_v ? 0 : -1;
            else                        p2 = p1 + 1;
            exp_pos[c+2] = p2;
            need = act(p2);
            if (need) begin
                miss_at[c+2] = emp_v;
                exp_rgb[c+2] = emp_v ? UF : 24'(base + 24'(model_reads));
                if (!emp_v) model_reads++;
            end
        end
        rd_now = vif.pix_rd;
        if (checking) begin
            px = (p < 0) ? 0 : p % HT;
            py = (p < 0) ? 0 : p / HT;
            chk("pix_rd", 32'(rd_now), 32'(need && !emp_v));
            chk("de", 32'(vif.de_out), 32'(act(p)));
            chk("x", 32'(vif.x_out), 32'(px));
            chk("y", 32'(vif.y_out), 32'(py));
            chk("hsync", 32'(vif.hsync_out),
                32'(p >= 0 && px >= HA + HF && px < HA + HF + HS));
            chk("vsync", 32'(vif.vsync_out),
                32'(p >= 0 && py >= VA + VF && py < VA + VF + VS));
            chk("frame_start", 32'(vif.frame_start), 32'(p == 0));
            chk("rgb", 32'(vif.rgb_out), act(p) ? 32'(exp_rgb[c]) : 32'd0);
            chk("underflow", 32'(underflow), 32'(exp_uf));
        end
        prev_rst = rst_v;
        prev_clr = clr_v;
        prev_uf = exp_uf;
        @(posedge clk);
        #1;
        if (rd_now) begin
            vif.pix_data = 24'(base + 24'(dut_reads));
            dut_reads++;
        end else begin
            vif.pix_data = 24'($urandom);
        end
        c++;
    endtask

    task automatic run_to(int pos);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (exp_pos[c] == pos) begin
                hit = 1'b1;
                break;
            end
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
        end
        n_cmp++;
        assert (hit) else begin
            n_err++;
            $error("FAIL run_to: position %0d not reached, at %0d", pos, exp_pos[c]);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            exp_pos[i] = -1;
            miss_at[i] = 1'b0;
            exp_rgb[i] = '0;
        end
        base = 24'($urandom);
        vif.pix_data = 24'($urandom);
        rst = 1'b1;
        en = 1'b0;
        underflow_clr = 1'b0;
        vif.pix_empty = 1'b0;

        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        checking = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // continuous streaming, three frames
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rd_count = 0;
        for (int i = 0; i < FT; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (rd_now) rd_count++;
        end
        chk("rd_per_frame", 32'(rd_count), 32'd12);
        for (int i = 0; i < 2 * FT; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // FIFO empty for pixel (2,1), then clear the flag
        for (int i = 0; i < FT + 5; i++)
            cyc(1'b1, exp_pos[c+1] == HT + 1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // en dropped mid-frame, frame completes, then restart
        run_to(20);
        for (int i = 0; i < 80; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // reset mid-line at x=2, y=1
        run_to(HT + 2);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // set and clear of underflow in the same cycle
        for (int i = 0; i < 20; i++)
            cyc(1'b1, exp_pos[c+1] == 0, 1'b0, exp_pos[c+1] == 1);

        // random traffic
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0,
                1'b0, $urandom_range(0, 15) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
